mux_scan_ctrl: RTL



---
 rtl/mux_scan_ctrl_if.sv | 25 ++
 rtl/mux_scan_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if
//   Frame handshake between the mux scan sequencer (master) and the frame
//   consumer (slave). The frame is qualified by frame_valid and retired on
//   the clock edge where frame_valid and frame_ready are both high.
//
//   frame_out    master -> slave   4-bit packed frame, bit c = channel c
//   frame_valid  master -> slave   frame_out holds a complete frame
//   frame_ready  slave  -> master  consumer accepts the frame
interface mux_scan_ctrl_if;
  logic [3:0] frame_out;
  logic       frame_valid;
  logic       frame_ready;

  modport master (
    output frame_out,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_out,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Select sequencer for a 4:1 mux. A start request steps sel through
//   channels 0..3. On each channel it waits SETTLE cycles, then samples
//   mux_y for one cycle. The four samples are packed into a 4-bit frame,
//   which is offered to the consumer on a valid/ready handshake.
//
//   Parameters
//     SETTLE       idle cycles after each select change before sampling (0..15)
//   Ports
//     clk          rising-edge clock
//     rst          synchronous, active-high reset
//     start        scan request, only looked at while idle
//     sel          mux select (drives mux S[1:0])
//     mux_y        mux output Y
//     busy         high whenever a scan or an unaccepted frame is in flight
//     frame        frame handshake (master side)
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | waiting for start; last frame_out still visible
//   ST_SETTLE  | select just changed, counting settle cycles
//   ST_SAMPLE  | capture mux_y for the current sel, then advance
//   ST_HOLD    | frame presented, waiting for frame_ready
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [1:0]             sel,
  input  logic                   mux_y,
  output logic                   busy,
  mux_scan_ctrl_if.master        frame
);

  // Terminal count of the settle counter. Unused when SETTLE is 0 because
  // the FSM bypasses ST_SETTLE entirely in that case.
  localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  localparam bit         NO_SETTLE   = (SETTLE == 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t     state,     state_nxt;
  logic [1:0] sel_q,     sel_nxt;
  logic [3:0] cnt_q,     cnt_nxt;
  logic [3:0] shadow_q,  shadow_nxt;
  logic [3:0] frame_q,   frame_nxt;
  logic       valid_q,   valid_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sel_q    <= 2'd0;
      cnt_q    <= 4'd0;
      shadow_q <= 4'd0;
      frame_q  <= 4'd0;
      valid_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      sel_q    <= sel_nxt;
      cnt_q    <= cnt_nxt;
      shadow_q <= shadow_nxt;
      frame_q  <= frame_nxt;
      valid_q  <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel_q;
    cnt_nxt    = cnt_q;
    shadow_nxt = shadow_q;
    frame_nxt  = frame_q;
    valid_nxt  = valid_q;

    case (state)
      ST_IDLE: begin
        if (start) begin
          sel_nxt    = 2'd0;
          cnt_nxt    = 4'd0;
          shadow_nxt = 4'd0;
          state_nxt  = NO_SETTLE ? ST_SAMPLE : ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        cnt_nxt = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_nxt = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        shadow_nxt[sel_q] = mux_y;
        if (sel_q != 2'd3) begin
          sel_nxt   = sel_q + 2'd1;
          cnt_nxt   = 4'd0;
          state_nxt = NO_SETTLE ? ST_SAMPLE : ST_SETTLE;
        end else begin
          // The channel-3 sample is merged straight into the frame since
          // shadow[3] only lands on this same edge.
          frame_nxt = {mux_y, shadow_q[2:0]};
          valid_nxt = 1'b1;
          sel_nxt   = 2'd0;
          state_nxt = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (valid_q && frame.frame_ready) begin
          valid_nxt = 1'b0;
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign sel               = sel_q;
  assign busy              = (state != ST_IDLE);
  assign frame.frame_out   = frame_q;
  assign frame.frame_valid = valid_q;

endmodule
